piso_serializer: RTL

Parallel-in serial-out stage that sits directly downstream of the 4-bit parallel register. It accepts one `WIDTH`-bit word per valid/ready handshake and shifts it out one bit per accepted cycle, LSB first by default. Output flow control is a ready/valid handshake, and a last-bit flag marks each frame. When the next word is presented in time, frames run back-to-back with no idle cycle.

---
 rtl/piso_serializer.sv | 80 ++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with ready/valid on both sides and a last-bit flag.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;

  logic w_on;
  logic w_last;
  logic w_load;
  logic w_adv;
  logic w_data_bit;
  logic w_bit;

  assign w_on       = (r_state == SHIFT) && !rst;
  assign w_last     = w_on && (r_cnt == CW'(1));
  assign w_adv      = w_on && so_ready;
  assign pi_ready   = !rst && ((r_state == IDLE) || (w_last && so_ready));
  assign w_load     = pi_valid && pi_ready;
  assign w_data_bit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking throughout, so load-over-advance priority sees pre-edge state.
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= SHIFT;
      r_sr    <= pi;
      r_cnt   <= CW'(FRAME_LEN);
    end else if (w_adv) begin
      r_sr  <= MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_state <= IDLE;
    end
  end

`ifdef PISO_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst)         r_par <= 1'b0;
    else if (w_load) r_par <= ^pi;
  end

  // The final slot of each frame carries the parity captured at load.
  assign w_bit = (r_cnt == CW'(1)) ? r_par : w_data_bit;
`else
  assign w_bit = w_data_bit;
`endif

  assign so       = w_on & w_bit;
  assign so_valid = w_on;
  assign so_last  = w_last;

endmodule
